// File: rtl/status_pkg.sv
// Shared status-digit constants and decoder FSM state type.
// Used by both the status encoder and decoder sides.
package status_pkg;

  localparam logic [3:0] CODE_ST0 = 4'hC;
  localparam logic [3:0] CODE_ST1 = 4'hA;
  localparam logic [3:0] CODE_ST2 = 4'hB;
  localparam logic [3:0] CODE_ST3 = 4'hD;

  // Match counter width; holds STABLE_CNT values up to 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // nothing committed since reset
    ST_CHECK  = 2'd1,  // counting repeats of a candidate
    ST_LOCKED = 2'd2   // status committed, no candidate
  } state_e;

endpackage

// File: rtl/status_code_lut.sv
// Combinational status-digit lookup.
//   stdig_in : 4-bit incoming status digit code
//   code_ok  : high when stdig_in is one of the four legal codes
//   std      : decoded 2-bit status (00 when code_ok is low)
module status_code_lut
  import status_pkg::*;
(
  input  logic [3:0] stdig_in,
  output logic       code_ok,
  output logic [1:0] std
);

  always_comb begin
    code_ok = 1'b1;
    std     = 2'b00;
    case (stdig_in)
      CODE_ST0: std = 2'b00;
      CODE_ST1: std = 2'b01;
      CODE_ST2: std = 2'b10;
      CODE_ST3: std = 2'b11;
      default:  code_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/modulo_status_decod.sv
// Status digit decoder with debounce-style commit.
//   clk, rst_n   : clock (rising edge), async active-low reset
//   stdig_in     : 4-bit status digit code, sampled when stdig_valid is high
//   clr_err      : synchronous clear of err_cnt
//   std_out      : last committed 2-bit status
//   std_valid    : high once any status has been committed
//   std_change   : one-cycle pulse on each commit
//   err          : one-cycle pulse after a strobed invalid code
//   err_cnt      : saturating count of strobed invalid codes
module modulo_status_decod
  import status_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 3,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       stdig_in,
  input  logic             stdig_valid,
  input  logic             clr_err,
  output logic [1:0]       std_out,
  output logic             std_valid,
  output logic             std_change,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] STABLE_CNT_C = CNT_W'(STABLE_CNT);

  state_e             state_q, state_d;
  logic [1:0]         cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         std_out_q, std_out_d;
  logic               std_valid_q, std_valid_d;
  logic               std_change_q, std_change_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic               code_ok;
  logic [1:0]         code_std;
  logic               strobe_ok;
  logic               strobe_bad;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ERR_W-1:0]   err_base;

  // Per-strobe events shared by the next-state and datapath processes.
  logic               do_commit;
  logic               do_start;
  logic               do_count;
  logic               do_drop;

  status_code_lut u_lut (
    .stdig_in (stdig_in),
    .code_ok  (code_ok),
    .std      (code_std)
  );

  assign strobe_ok  = stdig_valid & code_ok;
  assign strobe_bad = stdig_valid & ~code_ok;
  assign cnt_inc    = cnt_q + CNT_W'(1);

  always_comb begin
    do_commit = 1'b0;
    do_start  = 1'b0;
    do_count  = 1'b0;
    do_drop   = 1'b0;
    if (strobe_ok) begin
      case (state_q)
        ST_IDLE, ST_LOCKED: begin
          // In IDLE every code differs from the (uncommitted) status.
          if (!(state_q == ST_LOCKED && code_std == std_out_q)) begin
            if (STABLE_CNT == 1) do_commit = 1'b1;
            else                 do_start  = 1'b1;
          end
        end
        ST_CHECK: begin
          if (code_std == cand_q) begin
            if (cnt_inc == STABLE_CNT_C) do_commit = 1'b1;
            else                         do_count  = 1'b1;
          end else if (std_valid_q && code_std == std_out_q) begin
            do_drop = 1'b1;
          end else if (STABLE_CNT == 1) begin
            do_commit = 1'b1;
          end else begin
            do_start = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state process.
  always_comb begin
    state_d = state_q;
    if (strobe_bad)                state_d = std_valid_q ? ST_LOCKED : ST_IDLE;
    else if (do_commit || do_drop) state_d = ST_LOCKED;
    else if (do_start)             state_d = ST_CHECK;
  end

  // Registered output / datapath process.
  always_comb begin
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    std_out_d    = std_out_q;
    std_valid_d  = std_valid_q;
    std_change_d = 1'b0;
    err_d        = 1'b0;

    // Clear is applied before the increment so clr+invalid yields 1.
    err_base  = clr_err ? '0 : err_cnt_q;
    err_cnt_d = err_base;

    if (strobe_bad) begin
      err_d = 1'b1;
      cnt_d = '0;
      if (err_base != '1) err_cnt_d = err_base + ERR_W'(1);
    end else if (do_commit) begin
      std_out_d    = code_std;
      std_valid_d  = 1'b1;
      std_change_d = 1'b1;
      cnt_d        = '0;
    end else if (do_drop) begin
      cnt_d = '0;
    end else if (do_start) begin
      cand_d = code_std;
      cnt_d  = CNT_W'(1);
    end else if (do_count) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cand_q       <= '0;
      cnt_q        <= '0;
      std_out_q    <= '0;
      std_valid_q  <= 1'b0;
      std_change_q <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      std_out_q    <= std_out_d;
      std_valid_q  <= std_valid_d;
      std_change_q <= std_change_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign std_out    = std_out_q;
  assign std_valid  = std_valid_q;
  assign std_change = std_change_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule
